// File: rtl/forward_clarke_if.sv
// Handshake bundle for the forward Clarke stage: operand side (a/b/c) and result side
// (alpha/beta).
interface forward_clarke_if #(
  parameter int unsigned D_WIDTH = 19
);
  logic [D_WIDTH-1:0] a;
  logic [D_WIDTH-1:0] b;
  logic [D_WIDTH-1:0] c;
  logic               two_phase;
  logic               in_valid;
  logic               in_ready;
  logic [D_WIDTH-1:0] alpha;
  logic [D_WIDTH-1:0] beta;
  logic               sat;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output a, b, c, two_phase, in_valid, out_ready,
    input  in_ready, alpha, beta, sat, out_valid
  );

  modport slave (
    input  a, b, c, two_phase, in_valid, out_ready,
    output in_ready, alpha, beta, sat, out_valid
  );
endinterface

// File: rtl/forward_clarke.sv
// Sequential forward Clarke transform (a,b,c) -> (alpha,beta), amplitude-invariant,
// saturating, with one IDLE -> MUL -> OUT pass per operand set.
module forward_clarke #(
  parameter int unsigned D_WIDTH = 19,
  parameter int unsigned Q_BITS  = 15
) (
  input logic             clk,
  input logic             rst,
  forward_clarke_if.slave bus
);
  localparam int unsigned SW = D_WIDTH + 2;
  localparam int unsigned PW = D_WIDTH + 2 + Q_BITS + 1;

  // round(2^q / sqrt(3)) as round(sqrt(4^q / 3)), done in integers.
  function automatic longint unsigned ks_const(input int unsigned q);
    longint unsigned x;
    longint unsigned s;
    longint unsigned t;
    x = 64'd1 << (2 * q);
    s = 64'd0;
    for (int i = int'(q); i >= 0; i--) begin
      t = s | (64'd1 << i);
      if (3 * t * t <= x) s = t;
    end
    if (4 * x >= 12 * s * s + 12 * s + 3) s = s + 64'd1;
    return s;
  endfunction

  localparam longint unsigned K3 = ((64'd1 << Q_BITS) + 64'd1) / 3;
  localparam longint unsigned KS = ks_const(Q_BITS);
  localparam logic signed [PW-1:0] K3S = PW'(K3);
  localparam logic signed [PW-1:0] KSS = PW'(KS);
  localparam logic signed [PW-1:0] MaxV = {{(PW-D_WIDTH+1){1'b0}}, {(D_WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] MinV = {{(PW-D_WIDTH+1){1'b1}}, {(D_WIDTH-1){1'b0}}};

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StOut  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [D_WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic               tp_q, tp_d;
  logic [D_WIDTH-1:0] alpha_q, alpha_d, beta_q, beta_d;
  logic               sat_q, sat_d;

  logic signed [SW-1:0] ax, bx, cx, sum_al, sum_be;
  logic signed [PW-1:0] prod_al, prod_be, sh_al, sh_be;
  logic [D_WIDTH:0]     clip_al, clip_be;

  // Returns {clipped_flag, value}.
  function automatic logic [D_WIDTH:0] clip(input logic signed [PW-1:0] v);
    if (v > MaxV) return {1'b1, MaxV[D_WIDTH-1:0]};
    if (v < MinV) return {1'b1, MinV[D_WIDTH-1:0]};
    return {1'b0, v[D_WIDTH-1:0]};
  endfunction

  always_comb begin
    ax      = {{2{a_q[D_WIDTH-1]}}, a_q};
    bx      = {{2{b_q[D_WIDTH-1]}}, b_q};
    cx      = {{2{c_q[D_WIDTH-1]}}, c_q};
    sum_al  = ax + ax - bx - cx;
    sum_be  = tp_q ? (ax + bx + bx) : (bx - cx);
    prod_al = $signed({{(PW-SW){sum_al[SW-1]}}, sum_al}) * K3S;
    prod_be = $signed({{(PW-SW){sum_be[SW-1]}}, sum_be}) * KSS;
    sh_al   = prod_al >>> Q_BITS;
    sh_be   = prod_be >>> Q_BITS;
    clip_al = clip(sh_al);
    clip_be = clip(sh_be);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    tp_d    = tp_q;
    alpha_d = alpha_q;
    beta_d  = beta_q;
    sat_d   = sat_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          c_d     = bus.c;
          tp_d    = bus.two_phase;
          state_d = StMul;
        end
      end
      StMul: begin
        // Two-phase alpha is the a operand itself and can never clip.
        alpha_d = tp_q ? a_q : clip_al[D_WIDTH-1:0];
        beta_d  = clip_be[D_WIDTH-1:0];
        sat_d   = (clip_al[D_WIDTH] & ~tp_q) | clip_be[D_WIDTH];
        state_d = StOut;
      end
      StOut: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      tp_q    <= 1'b0;
      alpha_q <= '0;
      beta_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      tp_q    <= tp_d;
      alpha_q <= alpha_d;
      beta_q  <= beta_d;
      sat_q   <= sat_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StOut);
  assign bus.alpha     = alpha_q;
  assign bus.beta      = beta_q;
  assign bus.sat       = sat_q;
endmodule

// File: tb/tb_forward_clarke.sv
// Scoreboard bench for forward_clarke: driver pushes expected results on accept, monitor
// pops and compares on each output handshake.
module tb_forward_clarke;
  localparam int DW = 19;
  localparam int MAXV = (1 << (DW - 1)) - 1;
  localparam int MINV = -(1 << (DW - 1));

  typedef struct {
    int a, b, c;
    bit tp;
    bit use_model;
    int e_al, e_be;
    bit e_sat;
  } stim_t;

  typedef struct {
    int al, be;
    bit sat;
    int acc_edge;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  forward_clarke_if #(.D_WIDTH(DW)) bus ();
  forward_clarke #(.D_WIDTH(DW), .Q_BITS(15)) dut (.clk(clk), .rst(rst), .bus(bus));

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    n_cmp = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    or_mode = 1;  // 0 random out_ready, 1 always high, 2 held low
  bit    busy = 0;
  int    k3, ks;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic int sx(input logic [DW-1:0] v);
    return {{(32-DW){v[DW-1]}}, v};
  endfunction

  function automatic int rnd_d();
    logic [DW-1:0] r;
    r = DW'($urandom);
    return sx(r);
  endfunction

  // Reference: exact integer arithmetic, floor division by 2^15, then clip.
  function automatic exp_t model(input stim_t s);
    exp_t e;
    longint al, be;
    if (s.tp) begin
      al = s.a;
      be = (longint'(s.a) + 2 * longint'(s.b)) * ks;
    end else begin
      al = (2 * longint'(s.a) - s.b - s.c) * k3;
      be = (longint'(s.b) - s.c) * ks;
    end
    if (!s.tp) al = al >>> 15;
    be = be >>> 15;
    e.sat = 0;
    if (al > MAXV) begin al = MAXV; e.sat = 1; end
    if (al < MINV) begin al = MINV; e.sat = 1; end
    if (be > MAXV) begin be = MAXV; e.sat = 1; end
    if (be < MINV) begin be = MINV; e.sat = 1; end
    e.al = int'(al);
    e.be = int'(be);
    return e;
  endfunction

  // Driver: presents operands, holds them until accepted, scrambles them when idle.
  initial begin
    stim_t cur;
    bit acc_pending;
    exp_t e;
    acc_pending = 0;
    bus.in_valid = 0;
    bus.a = '0; bus.b = '0; bus.c = '0; bus.two_phase = 0;
    forever begin
      @(negedge clk);
      if (acc_pending) begin busy = 0; acc_pending = 0; end
      if (!busy) begin
        if (stim_q.size() > 0) begin
          cur = stim_q.pop_front();
          busy = 1;
          bus.a = DW'(cur.a); bus.b = DW'(cur.b); bus.c = DW'(cur.c);
          bus.two_phase = cur.tp;
          bus.in_valid = 1;
        end else begin
          bus.in_valid = 0;
          bus.a = DW'($urandom); bus.b = DW'($urandom); bus.c = DW'($urandom);
          bus.two_phase = 1'($urandom);
        end
      end
      if (busy && bus.in_ready) begin
        if (cur.use_model) e = model(cur);
        else begin e.al = cur.e_al; e.be = cur.e_be; e.sat = cur.e_sat; end
        e.acc_edge = cyc + 1;
        exp_q.push_back(e);
        acc_pending = 1;
      end
    end
  end

  // Monitor: drives out_ready, compares on handshake, checks hold/latency/ready rules.
  initial begin
    bit prev_ov, held, hs_prev;
    int h_al, h_be, h_sat;
    exp_t e;
    prev_ov = 0; held = 0; hs_prev = 0;
    bus.out_ready = 0;
    forever begin
      @(negedge clk);
      if (hs_prev) begin
        chk("in_ready_after_hs", int'(bus.in_ready), 1);
        chk("out_valid_after_hs", int'(bus.out_valid), 0);
      end
      hs_prev = 0;
      if (bus.out_valid && held) begin
        chk("hold_alpha", sx(bus.alpha), h_al);
        chk("hold_beta", sx(bus.beta), h_be);
        chk("hold_sat", int'(bus.sat), h_sat);
      end
      bus.out_ready = (or_mode == 1) ? 1'b1 : (or_mode == 2) ? 1'b0 : 1'($urandom);
      if (bus.out_valid) begin
        chk("in_ready_low_in_out", int'(bus.in_ready), 0);
        if (!prev_ov) begin
          if (exp_q.size() == 0) chk("spurious_out_valid", 1, 0);
          else chk("latency_edge", cyc, exp_q[0].acc_edge + 1);
        end
        if (bus.out_ready) begin
          if (exp_q.size() == 0) chk("result_without_accept", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("alpha", sx(bus.alpha), e.al);
            chk("beta", sx(bus.beta), e.be);
            chk("sat", int'(bus.sat), int'(e.sat));
          end
          hs_prev = 1;
          held = 0;
        end else begin
          held = 1;
          h_al = sx(bus.alpha); h_be = sx(bus.beta); h_sat = int'(bus.sat);
        end
      end else held = 0;
      prev_ov = bus.out_valid;
    end
  end

  task automatic push_dir(input int a, b, c, input bit tp, input int eal, ebe, input bit esat);
    stim_t s;
    s.a = a; s.b = b; s.c = c; s.tp = tp;
    s.use_model = 0; s.e_al = eal; s.e_be = ebe; s.e_sat = esat;
    stim_q.push_back(s);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((stim_q.size() > 0 || busy || exp_q.size() > 0 || bus.out_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk({"drain_timeout_", name}, 1, 0);
  endtask

  task automatic wait_out_valid(input string name);
    int n;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk({"out_valid_timeout_", name}, 1, 0);
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, "_in_ready"}, int'(bus.in_ready), 1);
    chk({name, "_out_valid"}, int'(bus.out_valid), 0);
    chk({name, "_alpha"}, sx(bus.alpha), 0);
    chk({name, "_beta"}, sx(bus.beta), 0);
    chk({name, "_sat"}, int'(bus.sat), 0);
  endtask

  initial begin
    stim_t s;
    k3 = $rtoi(32768.0 / 3.0 + 0.5);
    ks = $rtoi(32768.0 / $sqrt(3.0) + 0.5);
    repeat (3) @(negedge clk);
    chk_reset_state("reset_initial");
    rst = 0;

    // Directed points with hand-derived expectations.
    or_mode = 1;
    push_dir(3000, -1500, -1500, 0, 3000, 0, 0);
    push_dir(0, 1000, -1000, 0, 0, 1154, 0);
    push_dir(0, -1000, 1000, 0, 0, -1155, 0);
    push_dir(262143, -262144, -262144, 0, 262143, 0, 1);
    push_dir(1000, 0, 5000, 1, 1000, 577, 0);
    push_dir(-262144, 262143, 262143, 0, -262144, 0, 1);
    drain("directed");

    // Backpressure: result held while a second operand set waits with in_valid high.
    or_mode = 2;
    push_dir(0, 1000, -1000, 0, 0, 1154, 0);
    push_dir(3000, -1500, -1500, 0, 3000, 0, 0);
    wait_out_valid("bp");
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", int'(bus.in_ready), 0);
    end
    or_mode = 1;
    drain("bp");

    // Randomized traffic with random backpressure.
    or_mode = 0;
    for (int i = 0; i < 60; i++) begin
      s.a = rnd_d(); s.b = rnd_d(); s.c = rnd_d();
      if (i % 4 == 0) begin s.a = s.a / 64; s.b = s.b / 64; s.c = s.c / 64; end
      s.tp = 1'($urandom);
      s.use_model = 1; s.e_al = 0; s.e_be = 0; s.e_sat = 0;
      stim_q.push_back(s);
    end
    drain("random");

    // Reset mid-OUT with a pending saturated result.
    or_mode = 2;
    push_dir(262143, -262144, -262144, 0, 262143, 0, 1);
    wait_out_valid("rst");
    @(negedge clk);
    rst = 1;
    exp_q.delete();
    @(negedge clk);
    chk_reset_state("reset_mid_out");
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk_reset_state("reset_after_release");

    or_mode = 1;
    push_dir(1000, 0, 5000, 1, 1000, 577, 0);
    drain("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule
